// File: rtl/riscv_pkg.sv
// Shared types for the fetch/execute sequencer.
//   seq_state_t : sequencer FSM states
//   TRAP_*      : trap_cause encodings
package riscv_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    EXEC,
    HALTED
  } seq_state_t;

  localparam logic [1:0] TRAP_NONE     = 2'd0;
  localparam logic [1:0] TRAP_FETCH    = 2'd1;
  localparam logic [1:0] TRAP_MISALIGN = 2'd2;

endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and runs the fetch/execute loop.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req_valid/ready/addr          fetch request channel (addr = pc)
//   imem_rsp_valid/data/err            one-cycle fetch response
//   inst_valid, inst, pc               instruction presented to execute
//   exec_done, pc_next, halt           execute completion and next-PC
//   trap, trap_cause                   trap pulse and sticky cause
//   instret                            retired-instruction counter
//   idle                               high once halted
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned           PC_WIDTH   = 64,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_VEC  = '0,
  parameter logic [PC_WIDTH-1:0]   TRAP_VEC   = PC_WIDTH'(64'h100)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic                  exec_done,
  input  logic [PC_WIDTH-1:0]   pc_next,
  input  logic                  halt,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [63:0]           instret,
  output logic                  idle
);

  seq_state_t            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [63:0]           instret_q, instret_d;
  logic                  trap_q, trap_d;
  logic [1:0]            cause_q, cause_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VEC;
      inst_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= TRAP_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    instret_d      = instret_q;
    trap_d         = 1'b0;
    cause_d        = cause_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    idle           = 1'b0;

    unique case (state_q)
      BOOT: state_d = REQ;

      REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_d = WAIT;
      end

      WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            trap_d  = 1'b1;
            cause_d = TRAP_FETCH;
            pc_d    = TRAP_VEC;
            state_d = REQ;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        inst_valid = 1'b1;
        if (exec_done) begin
          // A misaligned target still retires the branch itself.
          instret_d = instret_q + 64'd1;
          state_d   = halt ? HALTED : REQ;
          if (pc_next[1:0] != 2'b00) begin
            trap_d  = 1'b1;
            cause_d = TRAP_MISALIGN;
            pc_d    = TRAP_VEC;
          end else begin
            pc_d = pc_next;
          end
        end
      end

      HALTED: idle = 1'b1;

      default: state_d = BOOT;
    endcase
  end

  assign imem_req_addr = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign instret       = instret_q;
  assign trap          = trap_q;
  assign trap_cause    = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        exec_done;
  logic [63:0] pc_next;
  logic        halt;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [63:0] instret;
  logic        idle;

  pc_sequencer #(
    .PC_WIDTH   (64),
    .INST_WIDTH (32),
    .RESET_VEC  (64'h0),
    .TRAP_VEC   (64'h100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .pc             (pc),
    .exec_done      (exec_done),
    .pc_next        (pc_next),
    .halt           (halt),
    .trap           (trap),
    .trap_cause     (trap_cause),
    .instret        (instret),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req_valid;
    logic [63:0] addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        trap;
    logic [1:0]  cause;
    logic [63:0] instret;
    logic        idle;
  } obs_t;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] data;
    logic        err;
    logic        ed;
    logic [63:0] pcn;
    logic        halt;
    obs_t        exp;
  } vec_t;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  vec_t        vecs[$];

  function automatic obs_t sample();
    obs_t o;
    o.req_valid  = imem_req_valid;
    o.addr       = imem_req_addr;
    o.inst_valid = inst_valid;
    o.inst       = inst;
    o.pc         = pc;
    o.trap       = trap;
    o.cause      = trap_cause;
    o.instret    = instret;
    o.idle       = idle;
    return o;
  endfunction

  // Expected observation; the fetch address always equals the PC.
  function automatic obs_t mko(logic rq, logic [63:0] p, logic iv, logic [31:0] in,
                               logic tr, logic [1:0] c, logic [63:0] ret, logic id);
    obs_t o;
    o.req_valid  = rq;
    o.addr       = p;
    o.inst_valid = iv;
    o.inst       = in;
    o.pc         = p;
    o.trap       = tr;
    o.cause      = c;
    o.instret    = ret;
    o.idle       = id;
    return o;
  endfunction

  task automatic add(logic rdy, logic rv, logic [31:0] d, logic er, logic ed,
                     logic [63:0] pcn, logic hl, obs_t e);
    vec_t v;
    v.ready = rdy; v.rv = rv; v.data = d; v.err = er;
    v.ed = ed; v.pcn = pcn; v.halt = hl; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_obs(string name, obs_t exp);
    obs_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic rdy, logic rv, logic [31:0] d, logic er, logic ed,
                       logic [63:0] pcn, logic hl);
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = d;
    imem_rsp_err = er; exec_done = ed; pc_next = pcn; halt = hl;
  endtask

  obs_t        zero;
  int unsigned n;

  initial begin
    zero = mko(1'b0, 64'h0, 1'b0, 32'h0, 1'b0, 2'd0, 64'd0, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    #1 check_obs("reset_async", zero);
    repeat (2) @(posedge clk);
    #1 check_obs("reset_held", zero);

    // inputs: ready rv data err exec_done pc_next halt ; expected after the edge
    add(1,0,32'h0,0,0,64'h0,0,        mko(1,64'h0,  0,32'h0,       0,2'd0,64'd0,0)); // BOOT->REQ
    add(1,0,32'h0,0,0,64'h0,0,        mko(0,64'h0,  0,32'h0,       0,2'd0,64'd0,0)); // accepted
    add(0,1,32'h13,0,0,64'h0,0,       mko(0,64'h0,  1,32'h13,      0,2'd0,64'd0,0)); // rsp
    add(0,0,32'h0,0,1,64'h4,0,        mko(1,64'h4,  0,32'h13,      0,2'd0,64'd1,0)); // retire
    for (int i = 0; i < 5; i++)
      add(0,0,32'h0,0,0,64'h0,0,      mko(1,64'h4,  0,32'h13,      0,2'd0,64'd1,0)); // stall
    add(1,0,32'h0,0,0,64'h0,0,        mko(0,64'h4,  0,32'h13,      0,2'd0,64'd1,0));
    add(1,0,32'h0,0,0,64'h0,0,        mko(0,64'h4,  0,32'h13,      0,2'd0,64'd1,0)); // one transfer only
    add(0,1,32'h00400093,0,0,64'h0,0, mko(0,64'h4,  1,32'h00400093,0,2'd0,64'd1,0));
    add(0,0,32'h0,0,1,64'h40,0,       mko(1,64'h40, 0,32'h00400093,0,2'd0,64'd2,0));
    add(1,0,32'h0,0,0,64'h0,0,        mko(0,64'h40, 0,32'h00400093,0,2'd0,64'd2,0));
    add(0,1,32'hdeadbeef,1,0,64'h0,0, mko(1,64'h100,0,32'h00400093,1,2'd1,64'd2,0)); // fetch err
    add(0,0,32'h0,0,0,64'h0,0,        mko(1,64'h100,0,32'h00400093,0,2'd1,64'd2,0)); // pulse ends
    add(1,0,32'h0,0,0,64'h0,0,        mko(0,64'h100,0,32'h00400093,0,2'd1,64'd2,0));
    add(0,1,32'h13,0,0,64'h0,0,       mko(0,64'h100,1,32'h13,      0,2'd1,64'd2,0));
    add(0,0,32'h0,0,1,64'h22,0,       mko(1,64'h100,0,32'h13,      1,2'd2,64'd3,0)); // misaligned
    add(1,0,32'h0,0,0,64'h0,0,        mko(0,64'h100,0,32'h13,      0,2'd2,64'd3,0));
    add(0,0,32'h0,0,1,64'h200,1,      mko(0,64'h100,0,32'h13,      0,2'd2,64'd3,0)); // stray exec_done
    add(0,1,32'h73,0,0,64'h0,1,       mko(0,64'h100,1,32'h73,      0,2'd2,64'd3,0));
    add(0,0,32'h0,0,0,64'h0,1,        mko(0,64'h100,1,32'h73,      0,2'd2,64'd3,0)); // hold in EXEC
    add(0,0,32'h0,0,1,64'h104,0,      mko(1,64'h104,0,32'h73,      0,2'd2,64'd4,0)); // halt dropped
    add(1,0,32'h0,0,0,64'h0,0,        mko(0,64'h104,0,32'h73,      0,2'd2,64'd4,0));
    add(0,1,32'h33,0,0,64'h0,0,       mko(0,64'h104,1,32'h33,      0,2'd2,64'd4,0));
    add(0,0,32'h0,0,1,64'h8,1,        mko(0,64'h8,  0,32'h33,      0,2'd2,64'd5,1)); // halt
    add(1,1,32'h55,0,1,64'hc,1,       mko(0,64'h8,  0,32'h33,      0,2'd2,64'd5,1)); // stray inputs
    add(1,0,32'h0,0,1,64'h10,0,       mko(0,64'h8,  0,32'h33,      0,2'd2,64'd5,1));

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].ready, vecs[i].rv, vecs[i].data, vecs[i].err,
            vecs[i].ed, vecs[i].pcn, vecs[i].halt);
      @(posedge clk);
      #1 check_obs($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset out of HALTED, then again while waiting on a response.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    rst_n = 1'b0;
    #1 check_obs("reset_from_halted", zero);
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    @(posedge clk);
    #1 check_obs("reboot_req", mko(1,64'h0,0,32'h0,0,2'd0,64'd0,0));
    @(posedge clk);
    #1 check_obs("reboot_wait", mko(0,64'h0,0,32'h0,0,2'd0,64'd0,0));
    #2 rst_n = 1'b0;
    #1 check_obs("reset_in_wait", zero);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!imem_req_valid && n < 4);
    check_val("first_req_latency", 64'(n), 64'd1);
    check_val("first_req_addr", imem_req_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
